spi_master_top: RTL and testbench
=================================

Name: spi_master_top

Overview:
- SPI master top for the board-to-board link demo.
- A debounced press on btn_send triggers one 96-bit full-duplex SPI frame: a 32-bit integer followed by a 64-bit IEEE-754 double.
- Words shifted in on MISO are published on i_data and i_float.
- Talks to the SPI slave top over SCLK_MASTER, SS_N_MASTER, MOSI_MASTER and MISO_MASTER.

Parameters:
- CLK_DIV, 25, clk cycles per SCLK half-period (50 MHz clk gives 1 MHz SCLK); must be at least 2.
- DEBOUNCE_CYCLES, 50000, cycles btn_send must stay stable before a level change is accepted (1 ms).
- TX_FLOAT, 64'h400921FB54442D18, double transmitted in every frame (pi).

Ports:
- clk, input, 1: system clock, 50 MHz.
- btn_reset, input, 1: reset. One clock; synchronous, active-high.
- btn_send, input, 1: asynchronous push-button, active-low (0 = pressed).
- SCLK_MASTER, output, 1: SPI clock, mode 0 (idles low).
- SS_N_MASTER, output, 1: slave select, active-low.
- MOSI_MASTER, output, 1: master data out.
- MISO_MASTER, input, 1: slave data in.
- status, output, 1: 1 = idle with valid received data; 0 = reset-idle or frame in progress.
- i_data, output, 32: integer word received in the last completed frame.
- i_float, output, 64: double received in the last completed frame.

Behaviour:
- Reset, while btn_reset=1 at a clk edge:
  - outputs: SCLK_MASTER=0, SS_N_MASTER=1, MOSI_MASTER=0, status=0, i_data=0, i_float=0.
  - internal: tx_count=0, FSM=IDLE, debouncer reads "released".
  - A reset mid-frame aborts it immediately; no partial update of i_data or i_float.
- Input conditioning:
  - btn_send passes through a 2-FF synchronizer, then the debouncer.
  - The debounced level changes only after the synchronized input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is the debounced released-to-pressed transition.
  - Exactly one event per press; holding the button never repeats.
- Transmit word:
  - tx_count is 32 bits.
  - On each accepted press: tx_count <= tx_count+1.
  - Frame payload = {tx_count_new, TX_FLOAT}, MSB first, 96 bits.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
  - IDLE: on a press event, load the shift register, drive MOSI_MASTER to bit 95, set SS_N_MASTER=0 and status=0, go to SETUP.
  - SETUP: wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT: SCLK_MASTER toggles every CLK_DIV cycles, giving 96 full SCLK periods.
    - Rising edge: sample MISO_MASTER into the receive register, MSB first.
    - Falling edge: shift MOSI_MASTER to the next bit, except after the 96th rising edge.
    - After the 96th falling edge, go to HOLD.
  - HOLD: wait CLK_DIV cycles, then in a single cycle:
    - set SS_N_MASTER=1;
    - i_data <= rx[95:64], i_float <= rx[63:0];
    - status <= 1;
    - MOSI_MASTER <= 0;
    - return to IDLE.
- Frame length is (96*2+2)*CLK_DIV cycles: 4850 cycles (97 us) at default.
- Press events arriving while not in IDLE are discarded.
- A press detected in the same cycle the frame ends is also discarded.
- i_data and i_float are held stable between frames.
- tx_count wraps from 32'hFFFFFFFF to 0.
- MISO_MASTER is sampled only while SS_N_MASTER=0.

Optional Feature:
- SPI_LOOPBACK_EN defined: the receive path samples the internal MOSI_MASTER value instead of the MISO_MASTER pin, and MISO_MASTER is ignored. After a frame, i_data equals the transmitted tx_count and i_float equals TX_FLOAT.
- SPI_LOOPBACK_EN not defined: normal operation, MISO_MASTER is sampled.

Test Plan:
- Reset held 2 ms, then released -> SS_N_MASTER=1, SCLK_MASTER=0, MOSI_MASTER=0, status=0, i_data=0, i_float=0, no SCLK activity.
- btn_send low for 6 ms with MISO tied to a slave driving {32'h12345678, 64'h3FF0000000000000} -> exactly one frame of 96 SCLK rising edges.
  - MOSI carries {32'h00000001, 64'h400921FB54442D18}.
  - After SS_N rises: i_data=32'h12345678, i_float=64'h3FF0000000000000, status=1.
- Two more 6 ms presses separated by 1 ms -> exactly two more frames; MOSI integer fields are 2 and 3.
- Glitches on btn_send shorter than DEBOUNCE_CYCLES (e.g. 100 us) -> no frame, outputs unchanged.
- btn_reset=1 asserted during SHIFT -> SS_N_MASTER=1 and SCLK_MASTER=0 on the next edge; i_data=0, status=0. The next press sends integer 1.
- With SPI_LOOPBACK_EN, one press -> i_data=32'h00000001, i_float=64'h400921FB54442D18, status=1.

Source files
------------

// File: rtl/spi_master_top.sv
// -----------------------------------------------------------------------------
// spi_master_top
//   SPI master for the board-to-board link demo. A debounced press on btn_send
//   sends one 96-bit full-duplex mode-0 frame: {tx_count, TX_FLOAT}, MSB first.
//   The 96 bits shifted in on MISO are published as {i_data, i_float} once the
//   frame completes.
//
// Ports
//   clk          in   system clock
//   btn_reset    in   synchronous active-high reset
//   btn_send     in   asynchronous push-button, active-low
//   SCLK_MASTER  out  SPI clock, idles low
//   SS_N_MASTER  out  slave select, active-low
//   MOSI_MASTER  out  master data out
//   MISO_MASTER  in   slave data in
//   status       out  1 = idle with valid received data
//   i_data       out  integer word from the last completed frame
//   i_float      out  double word from the last completed frame
//
// Optional feature
//   SPI_LOOPBACK_EN : receive path samples the internal MOSI value instead of
//                     the MISO_MASTER pin.
// -----------------------------------------------------------------------------
module spi_master_top #(
  parameter int          CLK_DIV         = 25,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [63:0] TX_FLOAT        = 64'h400921FB54442D18
) (
  input  logic        clk,
  input  logic        btn_reset,
  input  logic        btn_send,
  output logic        SCLK_MASTER,
  output logic        SS_N_MASTER,
  output logic        MOSI_MASTER,
  input  logic        MISO_MASTER,
  output logic        status,
  output logic [31:0] i_data,
  output logic [63:0] i_float
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state, next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [6:0]       bit_cnt;
  logic [95:0]      tx_sr;
  logic [95:0]      rx_sr;
  logic [31:0]      tx_count;
  logic [31:0]      tx_count_nxt;
  logic             sclk;
  logic             rx_bit;
  logic             div_done;

  // Button conditioning: 2-FF synchronizer then a stability counter.
  // btn_db is the debounced level, 1 = released.
  logic            btn_meta, btn_sync, btn_db;
  logic [DB_W-1:0] db_cnt;
  logic            press_evt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      btn_db   <= 1'b1;
      db_cnt   <= '0;
    end else begin
      btn_meta <= btn_send;
      btn_sync <= btn_meta;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Single-cycle pulse on the cycle the debounced level goes released->pressed.
  assign press_evt = btn_db & ~btn_sync & (db_cnt == DB_LAST);

  assign tx_count_nxt = tx_count + 32'd1;
  assign div_done     = (div_cnt == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = tx_sr[95];
`else
  assign rx_bit = MISO_MASTER;
`endif

  always_ff @(posedge clk) begin
    if (btn_reset) state <= IDLE;
    else           state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (press_evt) next_state = SETUP;
      SETUP: if (div_done) next_state = SHIFT;
      // The 96th falling edge is the one taken with bit_cnt already at 95.
      SHIFT: if (div_done && sclk && bit_cnt == 7'd95) next_state = HOLD;
      HOLD:  if (div_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the shift registers are cleared on reset as well; MOSI is taken from
  // tx_sr[95], so a cleared tx_sr is what makes MOSI idle low.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      tx_count <= '0;
      sclk     <= 1'b0;
      SS_N_MASTER <= 1'b1;
      status   <= 1'b0;
      i_data   <= '0;
      i_float  <= '0;
    end else begin
      if (state == IDLE || div_done) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (press_evt) begin
            tx_count    <= tx_count_nxt;
            tx_sr       <= {tx_count_nxt, TX_FLOAT};
            bit_cnt     <= '0;
            SS_N_MASTER <= 1'b0;
            status      <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_done) begin
            sclk <= ~sclk;
            if (!sclk) begin
              rx_sr <= {rx_sr[94:0], rx_bit};
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
              // No shift after the last rising edge: MOSI stays on bit 0
              // until the frame closes.
              if (bit_cnt != 7'd95) tx_sr <= {tx_sr[94:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (div_done) begin
            SS_N_MASTER <= 1'b1;
            i_data      <= rx_sr[95:64];
            i_float     <= rx_sr[63:0];
            status      <= 1'b1;
            tx_sr       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign SCLK_MASTER = sclk;
  assign MOSI_MASTER = tx_sr[95];

endmodule

// File: tb/tb_spi_master_top.sv
// -----------------------------------------------------------------------------
// tb_spi_master_top
//   Directed sequence with randomized slave data and glitch lengths. A slave
//   model drives MISO from a 96-bit word; a monitor records MOSI on SCLK rising
//   edges. Expected values come from a frame-level model: a press counter and
//   the word the slave was told to send.
// -----------------------------------------------------------------------------
module tb_spi_master_top;

  localparam int          CLK_DIV  = 3;
  localparam int          DEB      = 16;
  localparam logic [63:0] TX_FLOAT = 64'h400921FB54442D18;

  logic        clk = 1'b0;
  logic        btn_reset;
  logic        btn_send;
  logic        sclk, ss_n, mosi;
  logic        miso = 1'b0;
  logic        status;
  logic [31:0] i_data;
  logic [63:0] i_float;

  spi_master_top #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB), .TX_FLOAT(TX_FLOAT)
  ) dut (
    .clk(clk), .btn_reset(btn_reset), .btn_send(btn_send),
    .SCLK_MASTER(sclk), .SS_N_MASTER(ss_n), .MOSI_MASTER(mosi),
    .MISO_MASTER(miso), .status(status), .i_data(i_data), .i_float(i_float)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Slave model: presents bit 95 when selected, next bit after each SCLK fall.
  logic [95:0] slave_word = '0;
  logic [95:0] slave_sr   = '0;
  always @(negedge ss_n) begin
    slave_sr = slave_word;
    miso     = slave_sr[95];
  end
  always @(negedge sclk) begin
    if (!ss_n) begin
      slave_sr = {slave_sr[94:0], 1'b0};
      miso     = slave_sr[95];
    end
  end

  // Monitor: MOSI bits captured on rising SCLK, rising edges per frame,
  // completed frames (status rising).
  logic [95:0] mosi_cap    = '0;
  int          frame_rises = 0;
  int          total_rises = 0;
  int          frames_done = 0;
  always @(negedge ss_n) frame_rises = 0;
  always @(posedge sclk) begin
    mosi_cap    = {mosi_cap[94:0], mosi};
    frame_rises = frame_rises + 1;
    total_rises = total_rises + 1;
  end
  always @(posedge status) frames_done = frames_done + 1;

  // Reference model state.
  logic [31:0] exp_count = '0;
  logic [95:0] exp_rx    = '0;
  logic        exp_status = 1'b0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [95:0] rx_expect(input logic [95:0] sw, input logic [31:0] cnt);
`ifdef SPI_LOOPBACK_EN
    return {cnt, TX_FLOAT};
`else
    return sw;
`endif
  endfunction

  // One press held long enough for the whole frame, then a release; the model
  // advances by one frame.
  task automatic press_frame(input string tag, input logic [95:0] sw);
    int f0;
    f0 = frames_done;
    slave_word = sw;
    btn_send = 1'b0;
    cycles(3 * (194 * CLK_DIV) + DEB);
    btn_send = 1'b1;
    cycles(DEB + 20);
    exp_count  = exp_count + 32'd1;
    exp_rx     = rx_expect(sw, exp_count);
    exp_status = 1'b1;
    check({tag, "_frames"}, 96'(frames_done - f0), 96'd1);
    check({tag, "_rises"},  96'(frame_rises), 96'd96);
    check({tag, "_mosi"},   mosi_cap, {exp_count, TX_FLOAT});
    check({tag, "_i_data"}, 96'(i_data), 96'(exp_rx[95:64]));
    check({tag, "_i_float"},96'(i_float), 96'(exp_rx[63:0]));
    check({tag, "_status"}, 96'(status), 96'(exp_status));
  endtask

  initial begin
    int f0, r0, waited, glitch;
    btn_reset = 1'b1;
    btn_send  = 1'b1;
    cycles(40);
    check("rst_ss_n",   96'(ss_n),   96'd1);
    check("rst_sclk",   96'(sclk),   96'd0);
    check("rst_mosi",   96'(mosi),   96'd0);
    check("rst_status", 96'(status), 96'd0);
    check("rst_i_data", 96'(i_data), 96'd0);
    check("rst_i_float",96'(i_float),96'd0);
    btn_reset = 1'b0;
    r0 = total_rises;
    cycles(200);
    check("idle_no_sclk", 96'(total_rises - r0), 96'd0);
    check("idle_ss_n",    96'(ss_n), 96'd1);

    press_frame("f1", {32'h12345678, 64'h3FF0000000000000});
    press_frame("f2", {$urandom, $urandom, $urandom});
    cycles(DEB * 4);
    press_frame("f3", {$urandom, $urandom, $urandom});

    // Glitches shorter than the debounce window must not start a frame.
    f0 = frames_done;
    r0 = total_rises;
    for (int g = 0; g < 4; g++) begin
      glitch = $urandom_range(DEB - 2, 1);
      btn_send = 1'b0;
      cycles(glitch);
      btn_send = 1'b1;
      cycles(DEB + 10);
    end
    check("glitch_frames",  96'(frames_done - f0 + total_rises - r0), 96'd0);
    check("glitch_i_data",  96'(i_data),  96'(exp_rx[95:64]));
    check("glitch_i_float", 96'(i_float), 96'(exp_rx[63:0]));
    check("glitch_status",  96'(status),  96'(exp_status));

    // Reset while shifting aborts the frame and clears the counter.
    slave_word = {$urandom, $urandom, $urandom};
    btn_send = 1'b0;
    waited = 0;
    while (!(ss_n == 1'b0 && frame_rises >= 10) && waited < 2000) begin
      cycles(1);
      waited++;
    end
    check("mid_reach_shift", 96'(waited < 2000), 96'd1);
    btn_reset = 1'b1;
    btn_send  = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ss_n",   96'(ss_n),   96'd1);
    check("mid_sclk",   96'(sclk),   96'd0);
    check("mid_i_data", 96'(i_data), 96'd0);
    check("mid_i_float",96'(i_float),96'd0);
    check("mid_status", 96'(status), 96'd0);
    cycles(3);
    btn_reset  = 1'b0;
    exp_count  = '0;
    exp_status = 1'b0;
    cycles(DEB + 20);
    check("post_rst_idle", 96'(ss_n), 96'd1);

    press_frame("f4", {$urandom, $urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
